// File: rtl/suu_inst_fetch_pkg.sv
// rtl/suu_inst_fetch_pkg.sv - shared types and defaults for the instruction-fetch slice
package suu_inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'hBFC0_0000;
  localparam logic [31:0] ADDR_MASK_DEF = 32'h1FFF_FFFF;
  localparam int          ENTRY_W       = 65;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/suu_fetch_fifo.sv
// rtl/suu_fetch_fifo.sv - circular FIFO with flush; head reads as zero when empty
module suu_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

  // A pop on a full FIFO frees the slot the push writes into this same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/suu_inst_fetch.sv
// rtl/suu_inst_fetch.sv - PC sequencer, fetch FSM and instruction RAM port driver
module suu_inst_fetch
  import suu_inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] ADDR_MASK  = ADDR_MASK_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_ce_o,
  output logic        inst_we_o,
  output logic [31:0] inst_addr_o,
  output logic [3:0]  inst_sel_o,
  output logic [31:0] inst_wdata_o,
  input  logic [31:0] inst_rdata_i,
  input  logic        br_flag_i,
  input  logic [31:0] br_target_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o,
  output logic        out_adel_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic         fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic         fifo_count_unused;
  fetch_entry_t head, entry;
  logic         pop, space, redirect, fetch_ok, fetch_ce, adel_push, push;

  assign inst_we_o    = 1'b0;
  assign inst_sel_o   = 4'hF;
  assign inst_wdata_o = 32'h0;
  assign inst_addr_o  = pc_q & ADDR_MASK;
  assign inst_ce_o    = fetch_ce;

  assign out_valid_o  = ~fifo_empty;
  assign out_pc_o     = head.pc;
  assign out_inst_o   = head.inst;
  assign out_adel_o   = head.adel;
  assign fifo_count_unused = ^fifo_count;

  always_comb begin
    pop       = out_valid_o & out_ready_i;
    space     = ~fifo_full | pop;
    redirect  = br_flag_i & (state_q != ST_BOOT);
    fetch_ok  = (state_q == ST_FETCH) & ~redirect & space;
    fetch_ce  = fetch_ok & ~misaligned(pc_q);
    adel_push = fetch_ok & misaligned(pc_q);
    push      = fetch_ce | adel_push;
    entry.pc   = pc_q;
    entry.inst = fetch_ce ? inst_rdata_i : 32'h0;
    entry.adel = adel_push;

    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT:  state_d = misaligned(RESET_PC) ? ST_HALT : ST_FETCH;
      ST_FETCH: begin
        if (fetch_ce)  pc_d    = pc_q + 32'd4;
        if (adel_push) state_d = ST_HALT;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_HALT;
    endcase
    // Redirect wins over any push/pop decided above.
    if (redirect) begin
      pc_d    = br_target_i;
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  suu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .flush     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_suu_inst_fetch.sv
// tb/tb_suu_inst_fetch.sv - directed self-checking bench for suu_inst_fetch
module tb_suu_inst_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_ce_o, inst_we_o;
  logic [31:0] inst_addr_o, inst_wdata_o, inst_rdata_i;
  logic [3:0]  inst_sel_o;
  logic        br_flag_i;
  logic [31:0] br_target_i;
  logic        out_valid_o, out_ready_i, out_adel_o;
  logic [31:0] out_pc_o, out_inst_o;

  int checks = 0;
  int errors = 0;
  int pushes;

  always #5 clk = ~clk;

  // RAM model: word at offset 4A within the 64 KiB window holds 1000_0000 + 4A.
  always_comb inst_rdata_i = 32'h1000_0000 + {16'h0, inst_addr_o[15:0]};

  suu_inst_fetch dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_ce_o    (inst_ce_o),
    .inst_we_o    (inst_we_o),
    .inst_addr_o  (inst_addr_o),
    .inst_sel_o   (inst_sel_o),
    .inst_wdata_o (inst_wdata_o),
    .inst_rdata_i (inst_rdata_i),
    .br_flag_i    (br_flag_i),
    .br_target_i  (br_target_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_pc_o     (out_pc_o),
    .out_inst_o   (out_inst_o),
    .out_adel_o   (out_adel_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; out_ready_i = 1'b1; br_flag_i = 1'b0; br_target_i = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_ce", {31'h0, inst_ce_o}, 32'h0);
    chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
    chk("rst_pc", out_pc_o, 32'h0);
    chk("rst_inst", out_inst_o, 32'h0);
    chk("rst_adel", {31'h0, out_adel_o}, 32'h0);
    chk("const_we_sel_wdata", {inst_we_o, inst_sel_o, inst_wdata_o[26:0]}, {1'b0, 4'hF, 27'h0});
    resetn = 1'b1; #1;
    chk("boot_ce", {31'h0, inst_ce_o}, 32'h0);

    // Straight-line fetch with decode always ready
    cyc();
    chk("f0_addr", inst_addr_o, 32'h1FC0_0000);
    chk("f0_ce", {31'h0, inst_ce_o}, 32'h1);
    chk("f0_valid", {31'h0, out_valid_o}, 32'h0);
    cyc();
    chk("f1_addr", inst_addr_o, 32'h1FC0_0004);
    chk("f1_valid", {31'h0, out_valid_o}, 32'h1);
    chk("f1_outpc", out_pc_o, 32'hBFC0_0000);
    chk("f1_outinst", out_inst_o, 32'h1000_0000);
    cyc();
    chk("f2_addr", inst_addr_o, 32'h1FC0_0008);
    chk("f2_outpc", out_pc_o, 32'hBFC0_0004);
    chk("f2_outinst", out_inst_o, 32'h1000_0004);

    // Reset again, then backpressure from boot
    #2; resetn = 1'b0; out_ready_i = 1'b0; #1;
    chk("rst2_valid", {31'h0, out_valid_o}, 32'h0);
    cyc();
    resetn = 1'b1; #1;
    chk("boot2_ce", {31'h0, inst_ce_o}, 32'h0);
    pushes = 0;
    repeat (5) begin
      cyc();
      pushes += int'(inst_ce_o);
    end
    chk("bp_pushes", 32'(pushes), 32'd2);
    chk("bp_addr_hold", inst_addr_o, 32'h1FC0_0008);
    chk("bp_head", out_pc_o, 32'hBFC0_0000);
    out_ready_i = 1'b1; #1;
    chk("bp_full_pop_ce", {31'h0, inst_ce_o}, 32'h1);
    cyc();
    chk("bp_order1", out_pc_o, 32'hBFC0_0004);
    cyc();
    chk("bp_order2", out_pc_o, 32'hBFC0_0008);
    chk("bp_order2_inst", out_inst_o, 32'h1000_0008);

    // Redirect while full and draining
    br_flag_i = 1'b1; br_target_i = 32'h8000_0100; #1;
    chk("br_ce_forced", {31'h0, inst_ce_o}, 32'h0);
    cyc(); br_flag_i = 1'b0; #1;
    chk("br_flushed", {31'h0, out_valid_o}, 32'h0);
    chk("br_addr", inst_addr_o, 32'h0000_0100);
    chk("br_ce", {31'h0, inst_ce_o}, 32'h1);
    cyc();
    chk("br_outpc", out_pc_o, 32'h8000_0100);
    chk("br_outinst", out_inst_o, 32'h1000_0100);

    // Misaligned redirect target
    br_flag_i = 1'b1; br_target_i = 32'h8000_0102;
    cyc(); br_flag_i = 1'b0; #1;
    chk("mis_ce", {31'h0, inst_ce_o}, 32'h0);
    chk("mis_valid0", {31'h0, out_valid_o}, 32'h0);
    cyc();
    chk("mis_valid", {31'h0, out_valid_o}, 32'h1);
    chk("mis_adel", {31'h0, out_adel_o}, 32'h1);
    chk("mis_pc", out_pc_o, 32'h8000_0102);
    chk("mis_inst", out_inst_o, 32'h0);
    chk("halt_ce0", {31'h0, inst_ce_o}, 32'h0);
    cyc();
    chk("halt_valid1", {31'h0, out_valid_o}, 32'h0);
    chk("halt_ce1", {31'h0, inst_ce_o}, 32'h0);
    cyc();
    chk("halt_valid2", {31'h0, out_valid_o}, 32'h0);
    chk("halt_ce2", {31'h0, inst_ce_o}, 32'h0);
    br_flag_i = 1'b1; br_target_i = 32'h8000_0200;
    cyc(); br_flag_i = 1'b0; #1;
    chk("resume_ce", {31'h0, inst_ce_o}, 32'h1);
    chk("resume_addr", inst_addr_o, 32'h0000_0200);
    cyc();
    chk("resume_outpc", out_pc_o, 32'h8000_0200);

    // PC wrap
    br_flag_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
    cyc(); br_flag_i = 1'b0; #1;
    chk("wrap_addr0", inst_addr_o, 32'h1FFF_FFFC);
    chk("wrap_ce", {31'h0, inst_ce_o}, 32'h1);
    cyc();
    chk("wrap_addr1", inst_addr_o, 32'h0000_0000);
    chk("wrap_outpc0", out_pc_o, 32'hFFFF_FFFC);
    chk("wrap_outinst0", out_inst_o, 32'h1000_FFFC);
    cyc();
    chk("wrap_outpc1", out_pc_o, 32'h0000_0000);
    chk("wrap_outinst1", out_inst_o, 32'h1000_0000);

    // Async reset with two entries buffered
    out_ready_i = 1'b0;
    cyc();
    chk("ar_full_ce", {31'h0, inst_ce_o}, 32'h0);
    chk("ar_valid", {31'h0, out_valid_o}, 32'h1);
    out_ready_i = 1'b1; #1;
    chk("ar_pop_ce", {31'h0, inst_ce_o}, 32'h1);
    resetn = 1'b0; #1;
    chk("ar_valid0", {31'h0, out_valid_o}, 32'h0);
    chk("ar_ce0", {31'h0, inst_ce_o}, 32'h0);
    chk("ar_pc0", out_pc_o, 32'h0);
    cyc();
    resetn = 1'b1; #1;
    chk("ar_boot_ce", {31'h0, inst_ce_o}, 32'h0);
    cyc();
    chk("ar_restart_addr", inst_addr_o, 32'h1FC0_0000);
    chk("ar_restart_ce", {31'h0, inst_ce_o}, 32'h1);
    cyc();
    chk("ar_restart_outpc", out_pc_o, 32'hBFC0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
